// File: rtl/cell_stack.sv
// Hardware data stack: TOS held in a register for zero-latency reads, the
// remaining cells in a single-port synchronous RAM, with sticky error flags.
module cell_stack #(
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [AW:0]      depth,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  input  logic             clr_err
);

  localparam logic [AW:0] CAP     = (AW+1)'((1 << AW) + 1);
  localparam logic [1:0]  OP_PUSH = 2'b01;
  localparam logic [1:0]  OP_POP  = 2'b10;
  localparam logic [1:0]  OP_REPL = 2'b11;
  localparam logic [0:0]  IDLE    = 1'b0;
  localparam logic [0:0]  FILL    = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] ram [0:(1 << AW)-1];
  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic             accept;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             set_ovf;
  logic             set_unf;

  assign op_ready = (state == IDLE);
  assign empty    = (depth == '0);
  assign full     = (depth == CAP);

  assign accept  = op_valid && op_ready;
  assign do_push = accept && (op_code == OP_PUSH);
  assign do_pop  = accept && (op_code == OP_POP);
  assign do_repl = accept && (op_code == OP_REPL);
  assign set_ovf = do_push && full;
  assign set_unf = (do_pop || do_repl) && empty;

  // Address arithmetic is modulo 2^AW: the guards keep the true index in range.
  assign ram_we   = do_push && !empty && !full;
  assign ram_addr = do_pop ? depth[AW-1:0] - AW'(2) : depth[AW-1:0] - AW'(1);

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_addr] <= tos;
    rd_data <= ram[ram_addr];
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      depth <= '0;
      tos   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      // A new error wins over a simultaneous clear.
      if (set_ovf)      ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (set_unf)      unf <= 1'b1;
      else if (clr_err) unf <= 1'b0;

      case (state)
        IDLE: begin
          if (do_push && !full) begin
            tos   <= din;
            depth <= depth + (AW+1)'(1);
          end else if (do_pop && !empty) begin
            depth <= depth - (AW+1)'(1);
            if (depth == (AW+1)'(1)) tos <= '0;
            else                     state <= FILL;
          end else if (do_repl && !empty) begin
            tos <= din;
          end
        end
        FILL: begin
          tos   <= rd_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
